// File: rtl/aud_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package  : aud_ctrl_pkg                                                   |
// | Purpose  : Shared key-channel state type, key indices and counter sizing. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
package aud_ctrl_pkg;

    typedef enum logic [1:0] {
        S_UP        = 2'd0,
        S_DOWN_WAIT = 2'd1,
        S_DOWN      = 2'd2,
        S_UP_WAIT   = 2'd3
    } key_state_e;

    localparam int KEY_START = 0;
    localparam int KEY_PAUSE = 1;
    localparam int KEY_STOP  = 2;

    // One width serves both the debounce and the hold counter.
    function automatic int cnt_width(input int deb, input int hold);
        int m;
        m = (deb > hold) ? deb : hold;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aud_key_channel.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : aud_key_channel                                                |
// | Purpose  : One key: 2-flop synchroniser, debounce FSM, press/release/long |
// |            pulses. Long-press logic built only with AUD_KEY_LONG_PRESS_EN. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module aud_key_channel
    import aud_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 12_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release,
    output logic o_level,
    output logic o_long
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               w_s;
    key_state_e         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               r_press, r_release, r_level;
    logic               w_press_nxt, w_release_nxt, w_level_nxt;

    // Flops hold the raw active-low key, so reset to 1 reads as released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_key_n};
    end

    assign w_s       = ~r_sync[1];
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_one;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_level_nxt   = r_level;
        case (r_state)
            S_UP: begin
                if (w_s) begin
                    w_state_nxt = S_DOWN_WAIT;
                    w_cnt_nxt   = c_one;
                end
            end
            S_DOWN_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = S_UP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = S_DOWN;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DOWN: begin
                if (!w_s) begin
                    w_state_nxt = S_UP_WAIT;
                    w_cnt_nxt   = c_one;
                end
            end
            S_UP_WAIT: begin
                if (w_s) begin
                    w_state_nxt = S_DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt   = S_UP;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_UP;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_UP;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_level   <= w_level_nxt;
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_level   = r_level;

`ifdef AUD_KEY_LONG_PRESS_EN
    localparam logic [c_cnt_w-1:0] c_long_full = c_cnt_w'(LONG_CYCLES);
    localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_CYCLES - 1);

    logic [c_cnt_w-1:0] r_hold;
    logic               r_long;
    logic               w_enter_down;

    // Bounces through S_UP_WAIT pause the hold count but never clear it.
    assign w_enter_down = (r_state == S_DOWN_WAIT) && w_s && (r_cnt == c_deb_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_enter_down) begin
                r_hold <= '0;
            end else if ((r_state == S_DOWN) && w_s && (r_hold != c_long_full)) begin
                r_hold <= r_hold + c_one;
                if (r_hold == c_long_last) r_long <= 1'b1;
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/aud_key_conditioner.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : aud_key_conditioner                                            |
// | Purpose  : Bank of independent debounced key channels producing clean     |
// |            press/release/long pulses (long needs AUD_KEY_LONG_PRESS_EN).   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module aud_key_conditioner
    import aud_ctrl_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 12_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_long
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("aud_key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        aud_key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key_n   (i_key_n[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi]),
            .o_level   (o_level[gi]),
            .o_long    (o_long[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_aud_key_conditioner.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_aud_key_conditioner                                         |
// | Purpose  : Self-checking bench against a run-length debounce model.       |
// |            Long-press expectations follow AUD_KEY_LONG_PRESS_EN.           |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_aud_key_conditioner;

    localparam int NK = 3;
    localparam int DB = 8;
    localparam int LG = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] press, release_p, level, long_p;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    aud_key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_n   (key_n),
        .o_press   (press),
        .o_release (release_p),
        .o_level   (level),
        .o_long    (long_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model: the debounced level flips once the 2-sample-delayed key has
    // disagreed with it for DB consecutive samples.
    logic [NK-1:0] m_k1, m_k2, m_press, m_release, m_level, m_long;
    int            m_run [NK];
    logic          m_s;
    bit            m_down;
`ifdef AUD_KEY_LONG_PRESS_EN
    int            m_hold [NK];
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 = '1; m_k2 = '1;
            m_press = '0; m_release = '0; m_level = '0; m_long = '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] = 0;
`ifdef AUD_KEY_LONG_PRESS_EN
                m_hold[i] = 0;
`endif
            end
        end else begin
            for (int i = 0; i < NK; i++) begin
                m_s    = ~m_k2[i];
                m_down = m_level[i] && (m_run[i] == 0);
                m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
`ifdef AUD_KEY_LONG_PRESS_EN
                if (m_down && m_s && m_hold[i] < LG) begin
                    m_hold[i]++;
                    if (m_hold[i] == LG) m_long[i] = 1'b1;
                end
`endif
                if (m_s != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_level[i] = m_s;
                        m_run[i]   = 0;
                        if (m_s) begin
                            m_press[i] = 1'b1;
`ifdef AUD_KEY_LONG_PRESS_EN
                            m_hold[i] = 0;
`endif
                        end else begin
                            m_release[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_k2 = m_k1;
            m_k1 = key_n;
        end
    end

    task automatic test_reset();
        key_n = '1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({long_p, level, release_p, press} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {long_p, level, release_p, press}, 12'h000);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
        end
    endtask

    task automatic test_clean_press();
        int k, first, np;
        first = -1; np = 0;
        @(negedge clk);
        key_n[0] = 1'b0; k = cyc + 1;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0]) begin np++; if (first < 0) first = cyc; end
        end
        checks++;
        if (first != k + DB + 1) begin
            errors++;
            $display("FAIL clean_press_latency got=%0d exp=%0d", first, k + DB + 1);
        end
        checks++;
        if (np != 1) begin errors++; $display("FAIL clean_press_count got=%0d exp=1", np); end
        key_n[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL clean_release cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
        end
    endtask

    task automatic test_bounce();
        int vals[$], lens[$];
        int k, first, np, nb;
        vals = '{0, 1}; lens = '{5, 1};
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
            vals.push_back(0); lens.push_back($urandom_range(1, DB - 1));
            vals.push_back(1); lens.push_back($urandom_range(1, 3));
        end
        vals.push_back(0); lens.push_back(20);
        vals.push_back(1); lens.push_back(20);
        first = -1; np = 0; k = 0;
        @(negedge clk);
        for (int s = 0; s < vals.size(); s++) begin
            key_n[1] = vals[s][0];
            if (s == vals.size() - 2) k = cyc + 1;
            repeat (lens[s]) begin
                @(negedge clk);
                checks++;
                if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                    errors++;
                    $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc,
                             {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
                end
                if (press[1]) begin np++; if (first < 0) first = cyc; end
            end
        end
        checks++;
        if (np != 1) begin errors++; $display("FAIL bounce_count got=%0d exp=1", np); end
        checks++;
        if (first != k + DB + 1) begin
            errors++;
            $display("FAIL bounce_latency got=%0d exp=%0d", first, k + DB + 1);
        end
    endtask

    task automatic test_release_glitch(input int glitch);
        int k, first, np, nr;
        first = -1; np = 0; nr = 0;
        @(negedge clk);
        key_n[0] = 1'b0;
        repeat (15) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL glitch_hold cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
        end
        key_n[0] = 1'b1;
        repeat (glitch) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL glitch_high cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0]) np++;
            if (release_p[0]) nr++;
        end
        key_n[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL glitch_low cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0]) np++;
            if (release_p[0]) nr++;
        end
        key_n[0] = 1'b1; k = cyc + 1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL glitch_release cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0]) np++;
            if (release_p[0]) begin nr++; if (first < 0) first = cyc; end
        end
        checks++;
        if (np != 0 || nr != 1) begin
            errors++;
            $display("FAIL glitch_counts press=%0d release=%0d exp press=0 release=1", np, nr);
        end
        checks++;
        if (first != k + DB + 1) begin
            errors++;
            $display("FAIL glitch_release_latency got=%0d exp=%0d", first, k + DB + 1);
        end
    endtask

    task automatic test_simultaneous();
        int p0, p2, n1;
        p0 = -1; p2 = -1; n1 = 0;
        @(negedge clk);
        key_n[0] = 1'b0; key_n[2] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0] && p0 < 0) p0 = cyc;
            if (press[2] && p2 < 0) p2 = cyc;
            if (press[1]) n1++;
        end
        checks++;
        if (p0 < 0 || p0 != p2 || n1 != 0) begin
            errors++;
            $display("FAIL simultaneous_align p0=%0d p2=%0d p1count=%0d exp equal,>=0,0", p0, p2, n1);
        end
        key_n = '1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_long_press();
        int pc, lc, nl;
        pc = -1; lc = -1; nl = 0;
        @(negedge clk);
        key_n[2] = 1'b0;
        repeat (2 + DB + 60) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL long_press cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[2] && pc < 0) pc = cyc;
            if (long_p[2]) begin nl++; if (lc < 0) lc = cyc; end
        end
`ifdef AUD_KEY_LONG_PRESS_EN
        checks++;
        if (nl != 1 || lc != pc + LG) begin
            errors++;
            $display("FAIL long_press_timing count=%0d at=%0d exp count=1 at=%0d", nl, lc, pc + LG);
        end
`else
        checks++;
        if (nl != 0) begin errors++; $display("FAIL long_press_off got=%0d exp=0", nl); end
`endif
        key_n[2] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_press();
        int k, first, np;
        first = -1; np = 0;
        @(negedge clk);
        key_n[2] = 1'b0;
        repeat (14) @(negedge clk);
        key_n[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({long_p, level, release_p, press} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async got=%h exp=%h", {long_p, level, release_p, press}, 12'h000);
        end
        key_n[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; k = cyc + 1;
        repeat (15) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            if (press[0]) begin np++; if (first < 0) first = cyc; end
        end
        checks++;
        if (np != 1 || first != k + DB + 1) begin
            errors++;
            $display("FAIL reset_mid_latency count=%0d at=%0d exp count=1 at=%0d", np, first, k + DB + 1);
        end
        key_n = '1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        int dur [NK];
        for (int i = 0; i < NK; i++) dur[i] = $urandom_range(1, 20);
        repeat (2000) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
            for (int i = 0; i < NK; i++) begin
                dur[i]--;
                if (dur[i] == 0) begin
                    key_n[i] = ~key_n[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 80) : $urandom_range(1, 12);
                end
            end
        end
        key_n = '1;
        repeat (25) begin
            @(negedge clk);
            checks++;
            if ({long_p, level, release_p, press} !== {m_long, m_level, m_release, m_press}) begin
                errors++;
                $display("FAIL random_settle cyc=%0d got=%h exp=%h", cyc,
                         {long_p, level, release_p, press}, {m_long, m_level, m_release, m_press});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch(3);
        test_release_glitch($urandom_range(1, DB - 1));
        test_simultaneous();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
